// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : riscv_pkg                                                       |
// | Brief  : Shared register-file constants and writeback controller state.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package riscv_pkg;

   localparam int          REGFILE_SIZE        = 32;
   localparam int          REG_ADDR_W          = $clog2(REGFILE_SIZE);
   localparam logic [31:0] STACK_TOP_DEFAULT   = 32'h0000_2000;
   localparam logic [31:0] STACK_BYTES_DEFAULT = 32'h0000_0400;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : regfile_wb_ctrl                                                 |
// | Brief  : Register-file write port arbiter: init sweep, then pipeline WB. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module regfile_wb_ctrl
   import riscv_pkg::*;
#(
   parameter int          DWIDTH      = 32,
   parameter int          NUM_THREADS = 4,
   parameter int          INIT_SP     = 1,
   parameter logic [31:0] STACK_TOP   = STACK_TOP_DEFAULT,
   parameter logic [31:0] STACK_BYTES = STACK_BYTES_DEFAULT
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_wb_valid,
   input  logic [$clog2(NUM_THREADS)-1:0] i_wb_thread,
   input  logic [4:0]                     i_wb_rd,
   input  logic [DWIDTH-1:0]              i_wb_data,
   input  logic                           i_reinit,
   output logic                           o_wr_en,
   output logic [$clog2(NUM_THREADS)-1:0] o_thread_index_writeback,
   output logic [4:0]                     o_write_addr,
   output logic [DWIDTH-1:0]              o_write_data,
   output logic                           o_init_done
);

   localparam int            TW       = $clog2(NUM_THREADS);
   localparam int            CW       = $clog2(REGFILE_SIZE * NUM_THREADS);
   localparam logic [CW-1:0] CNT_LAST = CW'(REGFILE_SIZE * NUM_THREADS - 1);

   wb_state_e             state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [TW-1:0]         thread_q, thread_d;
   logic [4:0]            addr_q, addr_d;
   logic [DWIDTH-1:0]     data_q, data_d;
   logic                  init_done_q, init_done_d;

   // Thread stacks grow down from STACK_TOP, one STACK_BYTES slot per thread.
   function automatic logic [DWIDTH-1:0] sp_value(input logic [TW-1:0] tid);
      return DWIDTH'(STACK_TOP) - DWIDTH'(tid) * DWIDTH'(STACK_BYTES);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         thread_q    <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         thread_q    <= thread_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_reinit) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered, so the write presented next cycle is chosen here.
   always_comb begin
      wr_en_d     = 1'b0;
      thread_d    = '0;
      addr_d      = '0;
      data_d      = '0;
      init_done_d = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            wr_en_d  = 1'b1;
            thread_d = cnt_q[CW-1:REG_ADDR_W];
            addr_d   = cnt_q[REG_ADDR_W-1:0];
            if ((INIT_SP != 0) && (cnt_q[REG_ADDR_W-1:0] == REG_ADDR_W'(2))) begin
               data_d = sp_value(cnt_q[CW-1:REG_ADDR_W]);
            end
         end
         ST_RUN: begin
            if (!i_reinit) begin
               wr_en_d     = i_wb_valid && (i_wb_rd != 5'd0);
               thread_d    = i_wb_thread;
               addr_d      = i_wb_rd;
               data_d      = i_wb_data;
               init_done_d = 1'b1;
            end
         end
         default: begin
            wr_en_d = 1'b0;
         end
      endcase
   end

   assign o_wr_en                  = wr_en_q;
   assign o_thread_index_writeback = thread_q;
   assign o_write_addr             = addr_q;
   assign o_write_data             = data_q;
   assign o_init_done              = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_regfile_wb_ctrl                                              |
// | Brief  : Self-checking bench for regfile_wb_ctrl (NUM_THREADS=4).        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_ctrl;

   localparam int NT = 4;

   logic        clk;
   logic        reset;
   logic        i_wb_valid;
   logic [1:0]  i_wb_thread;
   logic [4:0]  i_wb_rd;
   logic [31:0] i_wb_data;
   logic        i_reinit;
   logic        o_wr_en;
   logic [1:0]  o_thread_index_writeback;
   logic [4:0]  o_write_addr;
   logic [31:0] o_write_data;
   logic        o_init_done;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_ctrl #(
      .DWIDTH      (32),
      .NUM_THREADS (NT),
      .INIT_SP     (1),
      .STACK_TOP   (32'h0000_2000),
      .STACK_BYTES (32'h0000_0400)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .i_wb_valid               (i_wb_valid),
      .i_wb_thread              (i_wb_thread),
      .i_wb_rd                  (i_wb_rd),
      .i_wb_data                (i_wb_data),
      .i_reinit                 (i_reinit),
      .o_wr_en                  (o_wr_en),
      .o_thread_index_writeback (o_thread_index_writeback),
      .o_write_addr             (o_write_addr),
      .o_write_data             (o_write_data),
      .o_init_done              (o_init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        valid;
      logic [1:0]  thread;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exp_wr;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [63:0] pk(input logic wr, input logic [1:0] th,
                                      input logic [4:0] a, input logic [31:0] d,
                                      input logic dn);
      return {23'd0, wr, th, a, d, dn};
   endfunction

   function automatic logic [63:0] dut_pk();
      return pk(o_wr_en, o_thread_index_writeback, o_write_addr, o_write_data, o_init_done);
   endfunction

   // Reference sweep: entry idx writes thread idx/32, register idx%32.
   function automatic logic [63:0] sweep_exp(input int idx);
      int          tid;
      int          r;
      logic [31:0] d;
      tid = idx / 32;
      r   = idx % 32;
      d   = (r == 2) ? (32'h2000 - 32'(tid) * 32'h400) : 32'd0;
      return pk(1'b1, tid[1:0], r[4:0], d, 1'b0);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_random_wb(input bit force_valid);
      i_wb_valid  = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
      i_wb_thread = 2'($urandom_range(0, NT - 1));
      i_wb_rd     = force_valid ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
      i_wb_data   = $urandom;
   endtask

   // Expects the next edge to present entry 0; pipeline writes stay valid throughout.
   task automatic run_sweep(input int n_entries, input int reinit_at);
      for (int i = 0; i < n_entries; i++) begin
         drive_random_wb(1'b1);
         i_reinit = (i == reinit_at);
         tick();
         check($sformatf("sweep[%0d]", i), dut_pk(), sweep_exp(i));
      end
      i_reinit = 1'b0;
      if (n_entries == 32 * NT) begin
         tick();
         check("init_done_first_run", dut_pk(),
               pk(i_wb_rd != 5'd0, i_wb_thread, i_wb_rd, i_wb_data, 1'b1));
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 2'd3, 5'd5,  32'hDEAD_BEEF, 1'b1};
      vecs[1] = '{1'b1, 2'd0, 5'd0,  32'h0000_1234, 1'b0};
      vecs[2] = '{1'b0, 2'd1, 5'd7,  32'h0000_0055, 1'b0};
      vecs[3] = '{1'b1, 2'd2, 5'd31, 32'hFFFF_FFFF, 1'b1};
      vecs[4] = '{1'b1, 2'd1, 5'd1,  32'h0000_0000, 1'b1};
      vecs[5] = '{1'b1, 2'd0, 5'd2,  32'h8000_0001, 1'b1};

      reset       = 1'b1;
      i_wb_valid  = 1'b0;
      i_wb_thread = 2'd0;
      i_wb_rd     = 5'd0;
      i_wb_data   = 32'd0;
      i_reinit    = 1'b0;
      tick();
      tick();
      check("reset_state", dut_pk(), 64'd0);

      reset = 1'b0;
      run_sweep(32 * NT, -1);

      foreach (vecs[k]) begin
         i_wb_valid  = vecs[k].valid;
         i_wb_thread = vecs[k].thread;
         i_wb_rd     = vecs[k].rd;
         i_wb_data   = vecs[k].data;
         tick();
         if (vecs[k].valid)
            check($sformatf("vec[%0d]", k), dut_pk(),
                  pk(vecs[k].exp_wr, vecs[k].thread, vecs[k].rd, vecs[k].data, 1'b1));
         else
            check($sformatf("vec[%0d]_idle", k), {62'd0, o_wr_en, o_init_done}, {62'd0, 1'b0, 1'b1});
      end

      for (int n = 0; n < 200; n++) begin
         drive_random_wb(1'b0);
         tick();
         if (i_wb_valid)
            check($sformatf("rand[%0d]", n), dut_pk(),
                  pk(i_wb_rd != 5'd0, i_wb_thread, i_wb_rd, i_wb_data, 1'b1));
         else
            check($sformatf("rand[%0d]_idle", n), {62'd0, o_wr_en, o_init_done}, {62'd0, 1'b0, 1'b1});
      end

      // Reinit alongside a valid write: the write is lost and the sweep reruns.
      i_reinit    = 1'b1;
      i_wb_valid  = 1'b1;
      i_wb_thread = 2'd2;
      i_wb_rd     = 5'd9;
      i_wb_data   = 32'hCAFE_F00D;
      tick();
      check("reinit_drop", {62'd0, o_wr_en, o_init_done}, 64'd0);
      i_reinit = 1'b0;
      run_sweep(32 * NT, 40);

      // Reset landing on sweep entry 60 restarts from entry 0.
      i_reinit = 1'b1;
      tick();
      i_reinit = 1'b0;
      check("reinit2_drop", {62'd0, o_wr_en, o_init_done}, 64'd0);
      run_sweep(61, -1);
      reset = 1'b1;
      tick();
      check("reset_mid_sweep", dut_pk(), 64'd0);
      reset = 1'b0;
      run_sweep(32 * NT, -1);

      // Reset during RUN also restarts the sweep.
      i_wb_valid  = 1'b1;
      i_wb_thread = 2'd1;
      i_wb_rd     = 5'd4;
      i_wb_data   = 32'h0BAD_CAFE;
      reset       = 1'b1;
      tick();
      check("reset_mid_run", dut_pk(), 64'd0);
      reset = 1'b0;
      run_sweep(4, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
